frame_update_ctrl: RTL

Frame-synchronous game-state controller for the VGA playfield. It runs once per frame, triggered by the vertical-blank start pulse from the sync counters. It steps the lane scroll offsets one lane per cycle, applies latched player hops, then resolves collisions and lives. The pixel renderer reads its registered outputs; the controller never touches pixel timing.

---
 rtl/game_pkg.sv | 46 ++++
 rtl/btn_edge_latch.sv | 38 +++
 rtl/frame_update_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game geometry, hop distances, lane wrap and controller state encoding.
// The sync generator and renderer import the same constants.
package game_pkg;

  localparam int H_DISPLAY     = 640;
  localparam int V_DISPLAY     = 480;
  localparam int PLAYER_WIDTH  = 30;
  localparam int PLAYER_HEIGHT = 50;
  localparam int HOP_X         = 35;
  localparam int HOP_Y         = 75;
  localparam int WRAP          = 35;

  // 11-bit forms so position arithmetic never wraps before clamping
  localparam logic [10:0] HOP_X_W = 11'(HOP_X);
  localparam logic [10:0] HOP_Y_W = 11'(HOP_Y);
  localparam logic [10:0] X_MAX_W = 11'(H_DISPLAY - PLAYER_WIDTH);
  localparam logic [10:0] Y_MAX_W = 11'(V_DISPLAY - PLAYER_HEIGHT);
  localparam logic [9:0]  WRAP_LAST = 10'(WRAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LANES  = 3'd1,
    ST_PLAYER = 3'd2,
    ST_HIT    = 3'd3,
    ST_DONE   = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  // Step toward zero, saturating at the top/left edge
  function automatic logic [9:0] pos_dec(input logic [9:0] pos, input logic [10:0] step);
    logic [10:0] wide;
    wide = {1'b0, pos};
    if (wide >= step) pos_dec = 10'(wide - step);
    else              pos_dec = '0;
  endfunction

  // Step away from zero, saturating at the last position that keeps the sprite on screen
  function automatic logic [9:0] pos_inc(input logic [9:0] pos, input logic [10:0] step,
                                         input logic [10:0] lim);
    logic [10:0] wide;
    wide = {1'b0, pos} + step;
    if (wide > lim) pos_inc = 10'(lim);
    else            pos_inc = 10'(wide);
  endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// Rising-edge detector feeding a sticky latch. The latch holds a press until the
// controller consumes it; a press landing on the consume cycle is kept.
module btn_edge_latch (
  input  logic CLK,
  input  logic RST_N,
  input  logic I_LEVEL,
  input  logic I_CLR,
  output logic O_LATCH
);

  logic level_reg;
  logic latch_reg;
  logic latch_next;
  logic edge_det;

  assign edge_det = I_LEVEL & ~level_reg;

  // Set has priority over clear so no press is lost
  always_comb begin
    latch_next = latch_reg;
    if (I_CLR)    latch_next = 1'b0;
    if (edge_det) latch_next = 1'b1;
  end

  // Previous button level and latch state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_reg <= 1'b0;
      latch_reg <= 1'b0;
    end else begin
      level_reg <= I_LEVEL;
      latch_reg <= latch_next;
    end
  end

  assign O_LATCH = latch_reg;

endmodule

// File: rtl/frame_update_ctrl.sv
// Once-per-frame game-state update: steps lane scroll offsets one lane per cycle,
// applies latched hops, then resolves a pending collision against the life count.
module frame_update_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LANES   = 5,
  parameter int BASE_DIV    = 4,
  parameter int START_X     = 305,
  parameter int START_Y     = 430,
  parameter int START_LIVES = 3
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    I_FRAME_START,
  input  logic                    I_BTN_UP,
  input  logic                    I_BTN_DOWN,
  input  logic                    I_BTN_LEFT,
  input  logic                    I_BTN_RIGHT,
  input  logic                    I_COLLISION,
  output logic [10*NUM_LANES-1:0] O_LANE_OFFSET,
  output logic [9:0]              O_PLAYER_X,
  output logic [9:0]              O_PLAYER_Y,
  output logic [1:0]              O_LIVES,
  output logic                    O_BUSY,
  output logic                    O_DONE,
  output logic                    O_HIT,
  output logic                    O_GAME_OVER
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W = $clog2(BASE_DIV * NUM_LANES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_LANES - 1);
  localparam logic [9:0]       START_X_W   = 10'(START_X);
  localparam logic [9:0]       START_Y_W   = 10'(START_Y);
  localparam logic [1:0]       START_LIVES_W = 2'(START_LIVES);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] lane_idx_reg, lane_idx_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic [1:0]       lives_reg, lives_next;
  logic             coll_reg, coll_next;
  logic             up_lat, down_lat, left_lat, right_lat;
  logic             latch_clr;
  logic             hit_apply;

  assign latch_clr = (state_reg == ST_PLAYER);
  assign hit_apply = (state_reg == ST_HIT) && coll_reg;

  btn_edge_latch u_up    (.CLK(CLK), .RST_N(RST_N), .I_LEVEL(I_BTN_UP),    .I_CLR(latch_clr), .O_LATCH(up_lat));
  btn_edge_latch u_down  (.CLK(CLK), .RST_N(RST_N), .I_LEVEL(I_BTN_DOWN),  .I_CLR(latch_clr), .O_LATCH(down_lat));
  btn_edge_latch u_left  (.CLK(CLK), .RST_N(RST_N), .I_LEVEL(I_BTN_LEFT),  .I_CLR(latch_clr), .O_LATCH(left_lat));
  btn_edge_latch u_right (.CLK(CLK), .RST_N(RST_N), .I_LEVEL(I_BTN_RIGHT), .I_CLR(latch_clr), .O_LATCH(right_lat));

  // State and lane index registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      lane_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lane_idx_reg <= lane_idx_next;
    end
  end

  // Sequence: lanes one per cycle, then player, then collision resolution
  always_comb begin
    state_next    = state_reg;
    lane_idx_next = lane_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (I_FRAME_START) begin
          state_next    = ST_LANES;
          lane_idx_next = '0;
        end
      end
      ST_LANES: begin
        if (lane_idx_reg == LAST_IDX) state_next = ST_PLAYER;
        else lane_idx_next = lane_idx_reg + IDX_W'(1);
      end
      ST_PLAYER: state_next = ST_HIT;
      ST_HIT: begin
        if (coll_reg && (lives_reg == 2'd1)) state_next = ST_OVER;
        else                                 state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      ST_OVER: state_next = ST_OVER;
      default: state_next = ST_IDLE;
    endcase
  end

  // Player position and lives: hops in PLAYER, respawn and life loss in HIT
  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    lives_next = lives_reg;
    if (state_reg == ST_PLAYER) begin
      if (up_lat)        y_next = pos_dec(y_reg, HOP_Y_W);
      else if (down_lat) y_next = pos_inc(y_reg, HOP_Y_W, Y_MAX_W);
      if (left_lat)       x_next = pos_dec(x_reg, HOP_X_W);
      else if (right_lat) x_next = pos_inc(x_reg, HOP_X_W, X_MAX_W);
    end else if (hit_apply) begin
      x_next     = START_X_W;
      y_next     = START_Y_W;
      lives_next = lives_reg - 2'd1;
    end
  end

  // Sticky collision flag; a fresh collision in the HIT cycle survives the clear
  always_comb begin
    coll_next = coll_reg;
    if (state_reg != ST_OVER) begin
      if (hit_apply)   coll_next = 1'b0;
      if (I_COLLISION) coll_next = 1'b1;
    end
  end

  // Player, lives and collision registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_reg     <= START_X_W;
      y_reg     <= START_Y_W;
      lives_reg <= START_LIVES_W;
      coll_reg  <= 1'b0;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      lives_reg <= lives_next;
      coll_reg  <= coll_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BASE_DIV * (gi + 1) - 1);
      localparam bit               STEP_DOWN = (gi % 2) == 1;
      logic [CNT_W-1:0] cnt_reg;
      logic [9:0]       offset_reg;
      logic             lane_sel;

      assign lane_sel = (state_reg == ST_LANES) && (lane_idx_reg == IDX_W'(gi));

      // Frame divider and scroll offset; odd lanes scroll the opposite way
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          cnt_reg    <= '0;
          offset_reg <= '0;
        end else if (lane_sel) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            if (STEP_DOWN) offset_reg <= (offset_reg == 10'd0) ? WRAP_LAST : offset_reg - 10'd1;
            else           offset_reg <= (offset_reg == WRAP_LAST) ? 10'd0 : offset_reg + 10'd1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign O_LANE_OFFSET[gi*10 +: 10] = offset_reg;
    end
  endgenerate

  assign O_PLAYER_X  = x_reg;
  assign O_PLAYER_Y  = y_reg;
  assign O_LIVES     = lives_reg;
  assign O_BUSY      = (state_reg == ST_LANES) || (state_reg == ST_PLAYER) ||
                       (state_reg == ST_HIT)   || (state_reg == ST_DONE);
  assign O_DONE      = (state_reg == ST_DONE);
  assign O_HIT       = hit_apply;
  assign O_GAME_OVER = (state_reg == ST_OVER);

endmodule
